// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: one full-subtractor cell and a registered borrow, LSB first.
// Define RST_SIGNED_OVF_EN to add the registered two's-complement overflow flag o_overflow.
module serial_ripple_subtractor #(
  parameter int WIDTH = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result
`ifdef RST_SIGNED_OVF_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic             bw;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] diff_sr;
  logic [WIDTH-1:0] diff_next;
  logic             a_bit, b_bit, d_bit, bw_next, last_bit;

  assign a_bit     = a_sr[0];
  assign b_bit     = b_sr[0];
  assign d_bit     = a_bit ^ b_bit ^ bw;
  assign bw_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw);
  assign last_bit  = (cnt == LAST);
  // The top bit of diff_next is the newest bit; on the final bit it is the complete difference.
  assign diff_next = {d_bit, diff_sr};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_next = RUN;
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      bw         <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      diff_sr    <= '0;
      o_result   <= '0;
`ifdef RST_SIGNED_OVF_EN
      o_overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_sr <= i_minuend;
            b_sr <= i_subtrahend;
            bw   <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          diff_sr <= diff_next[WIDTH-1:1];
          bw      <= bw_next;
          if (last_bit) begin
            o_result   <= {bw_next, diff_next};
`ifdef RST_SIGNED_OVF_EN
            // On the last bit the cells hold the operand sign bits and d_bit is the result sign.
            o_overflow <= (a_bit != b_bit) && (d_bit != a_bit);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench for serial_ripple_subtractor: arithmetic reference model, queue of expected results,
// independent monitor. Checks o_overflow too when RST_SIGNED_OVF_EN is defined.
module tb_serial_ripple_subtractor;

  localparam int W = 7;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_minuend;
  logic [W-1:0] i_subtrahend;
  logic         o_valid;
  logic         i_ready;
  logic [W:0]   o_result;
`ifdef RST_SIGNED_OVF_EN
  logic         o_overflow;
`endif

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_minuend    (i_minuend),
    .i_subtrahend (i_subtrahend),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result)
`ifdef RST_SIGNED_OVF_EN
    ,
    .o_overflow   (o_overflow)
`endif
  );

  typedef struct {
    logic [W:0] res;
    logic       ovf;
    int         hs_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  bit   rand_ready = 0;
  bit   ready_force = 1;
  bit   seen       = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      i_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Reference model: plain unsigned and signed arithmetic on the operands.
  function automatic exp_t model(int a, int b, int hs);
    exp_t e;
    int d, sa, sb, sd;
    logic [W-1:0] dl;
    d  = a - b;
    dl = d[W-1:0];
    sa = (a >= 2**(W-1)) ? a - 2**W : a;
    sb = (b >= 2**(W-1)) ? b - 2**W : b;
    sd = sa - sb;
    e.res    = {(a < b) ? 1'b1 : 1'b0, dl};
    e.ovf    = (sd > 2**(W-1) - 1) || (sd < -(2**(W-1)));
    e.hs_cyc = hs;
    return e;
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds i_valid until the handshake edge and queues the expected response.
  task automatic apply_stimulus(int a, int b);
    int n;
    i_valid      = 1'b1;
    i_minuend    = a[W-1:0];
    i_subtrahend = b[W-1:0];
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: o_ready=%0b, required 1", o_ready);
    end else begin
      exp_q.push_back(model(a, b, cyc));
    end
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
    end else if (o_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_valid: o_valid=1 result=0x%0h, required no output", o_result);
      end else begin
        if (!seen) begin
          check_output("latency", cyc - exp_q[0].hs_cyc, W + 1);
          seen = 1;
        end
        check_output("result", 32'(o_result), 32'(exp_q[0].res));
        check_output("ready_in_done", 32'(o_ready), 0);
`ifdef RST_SIGNED_OVF_EN
        check_output("overflow", 32'(o_overflow), 32'(exp_q[0].ovf));
`endif
        if (i_ready) begin
          void'(exp_q.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    rst_n        = 1'b0;
    i_valid      = 1'b0;
    i_minuend    = '0;
    i_subtrahend = '0;
    repeat (2) @(negedge clk);
    check_output("reset_valid", 32'(o_valid), 0);
    check_output("reset_ready", 32'(o_ready), 1);
    check_output("reset_result", 32'(o_result), 0);
`ifdef RST_SIGNED_OVF_EN
    check_output("reset_overflow", 32'(o_overflow), 0);
`endif
    rst_n = 1'b1;
    tick();

    $display("[TB] directed operands");
    apply_stimulus(100, 37);
    apply_stimulus(37, 100);
    apply_stimulus(0, 1);
    apply_stimulus(8'h55, 8'h55);
    apply_stimulus(0, 2**W - 1);
    apply_stimulus(2**W - 1, 0);
    apply_stimulus(8'h40, 8'h01);
    apply_stimulus(8'h3F, 8'h7F);
    wait_drain();

    $display("[TB] backpressure");
    ready_force = 1'b0;
    tick();
    apply_stimulus(100, 37);
    begin
      int n;
      n = 0;
      while (!o_valid && n < 50) begin
        tick();
        n++;
      end
    end
    i_valid      = 1'b1;
    i_minuend    = 7'd5;
    i_subtrahend = 7'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output("bp_valid_held", 32'(o_valid), 1);
      check_output("bp_ready_low", 32'(o_ready), 0);
      tick();
    end
    ready_force = 1'b1;
    apply_stimulus(5, 9);
    wait_drain();

    $display("[TB] operands toggled during run");
    apply_stimulus(100, 37);
    for (int k = 0; k < W; k++) begin
      i_valid      = 1'($urandom_range(0, 1));
      i_minuend    = W'($urandom);
      i_subtrahend = W'($urandom);
      tick();
    end
    i_valid = 1'b0;
    wait_drain();

    $display("[TB] reset during run");
    apply_stimulus(50, 20);
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check_output("abort_valid", 32'(o_valid), 0);
    check_output("abort_ready", 32'(o_ready), 1);
    check_output("abort_result", 32'(o_result), 0);
    exp_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < W + 4; k++) tick();
    apply_stimulus(10, 3);
    wait_drain();

    $display("[TB] randomized traffic");
    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      apply_stimulus(int'($urandom_range(0, 2**W - 1)), int'($urandom_range(0, 2**W - 1)));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_drain();
    rand_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Bit-serial ripple-borrow subtractor; the inverse operation of the team's ripple-carry adder.
- Computes i_minuend - i_subtrahend one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Used where area matters more than latency. Sits behind a valid/ready producer and in front of a valid/ready consumer.
- Result format is {borrow_out, difference}, matching the adder's {carry, sum} packing, so the two are interchangeable downstream.

Parameters:
- WIDTH, 7, operand width in bits; must be >= 2.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  producer presents operands.
- o_ready  output  1  block can accept operands; high only in IDLE.
- i_minuend  input  WIDTH  operand A.
- i_subtrahend  input  WIDTH  operand B.
- o_valid  output  1  o_result is valid; high only in DONE.
- i_ready  input  1  consumer accepts result.
- o_result  output  WIDTH+1  {borrow_out, A-B mod 2^WIDTH}.

Behaviour:
- Reset: asynchronous on i_rst_n low. State=IDLE, bit counter=0, borrow=0, operand and difference shift registers=0, o_result=0, o_valid=0, o_ready=1 (combinational from state). If RST_SIGNED_OVF_EN is defined, o_overflow=0.
- States:
  - IDLE: o_ready=1. On i_valid&&o_ready, latch A and B, clear borrow and counter, go to RUN.
  - RUN: one bit per cycle at index cnt.
    - d = a^b^bw.
    - bw_next = (~a&b) | (~(a^b)&bw).
    - d is shifted into the difference register MSB-first, so LSB ends at bit 0.
    - cnt increments each cycle. When cnt==WIDTH-1, the bit is processed, o_result is loaded with {bw_next, full difference}, and the state goes to DONE.
  - DONE: o_valid=1. On i_ready, go to IDLE.
- Latency: handshake in cycle 0, RUN in cycles 1..WIDTH, o_valid high from cycle WIDTH+1. Minimum initiation interval is WIDTH+2 cycles (DONE->IDLE costs one cycle; no accept in DONE).
- o_result changes only on the RUN->DONE transition. It holds its value through DONE, in IDLE after handoff, and across any backpressure duration.
- i_valid, i_minuend and i_subtrahend are ignored outside IDLE. Operand changes during RUN do not affect the result.
- i_ready while not in DONE has no effect.
- Borrow semantics: borrow_out=1 iff A<B (unsigned).
  - A==B gives all zeros.
  - 0-(2^WIDTH-1) gives difference 1, borrow 1.
- Reset asserted mid-RUN or mid-DONE aborts immediately. The pending result is discarded and never presented.
- Counter width is clog2(WIDTH). No wrap-around: the counter never advances past WIDTH-1.

Optional Feature:
- Macro: RST_SIGNED_OVF_EN.
- When defined:
  - Adds output port o_overflow, 1 bit, registered.
  - Loaded on RUN->DONE with two's-complement overflow = (A[MSB]!=B[MSB]) && (diff[MSB]!=A[MSB]).
  - Valid with o_valid; held like o_result; reset to 0.
- When undefined:
  - The port does not exist and no overflow logic is synthesised.
  - All other behaviour is identical.

Test Plan:
- WIDTH=7, A=100, B=37, i_ready=1 -> o_valid in cycle 8 after handshake; o_result=8'h3F; o_valid high exactly 1 cycle.
- A=37, B=100 -> o_result=8'hC1 (diff 0x41, borrow 1). A=0, B=1 -> 8'hFF. A=B=0x55 -> 8'h00.
- Backpressure: result 8'h3F ready, i_ready low 5 cycles while i_valid=1 with new operands -> o_valid, o_result stable; o_ready=0; nothing accepted. i_ready high -> IDLE next cycle, o_ready=1, the new operands are accepted the following cycle.
- Operands toggled every cycle during RUN -> result reflects only the values latched at the handshake.
- i_rst_n pulsed low in RUN cycle 3 -> outputs immediately at reset values; after release, o_valid stays 0 until a new handshake; the next op A=10, B=3 returns 8'h07.
- RST_SIGNED_OVF_EN defined:
  - A=0x40, B=0x01 -> o_result=8'h3F, o_overflow=1.
  - A=0x3F, B=0x7F -> o_result=8'hC0, o_overflow=1.
  - A=100, B=37 -> o_overflow=0.
